// File: rtl/ulx3s_button_receiver.sv
// ulx3s_button_receiver
// Receives the ULX3S push-buttons on the fabric clock. Each channel is
// synchronised through two flops and debounced with a counter. The block
// produces a clean level plus one-cycle press and release pulses.
// All outputs are registered.
// Optional feature: define BUTTON_AUTOREPEAT_EN to add a per-channel
// auto-repeat. Repeat press pulses start RepeatDelay cycles after the
// accepted press and then recur every RepeatPeriod cycles.
module ulx3s_button_receiver #(
  parameter int NumButtons     = 3,
  parameter int DebounceCycles = 50000,
  parameter int RepeatDelay    = 25000000,
  parameter int RepeatPeriod   = 5000000
) (
  input  logic                  clk_i,
  input  logic                  reset_i,
  input  logic [NumButtons-1:0] btn_i,
  output logic [NumButtons-1:0] btn_level_o,
  output logic [NumButtons-1:0] btn_press_o,
  output logic [NumButtons-1:0] btn_release_o
);

  localparam int            CW      = $clog2(DebounceCycles + 1);
  localparam logic [CW-1:0] CntLast = CW'(DebounceCycles - 1);

  // Every count must be at least one cycle long.
  if (NumButtons < 1 || DebounceCycles < 1 || RepeatDelay < 1 || RepeatPeriod < 1) begin : g_bad_params
    $error("ulx3s_button_receiver: all parameters must be >= 1");
  end

  logic [NumButtons-1:0] sync1_q, sync2_q;
  logic [NumButtons-1:0] level_q, level_d;
  logic [NumButtons-1:0] press_q, press_d, press_out_d;
  logic [NumButtons-1:0] release_q, release_d;
  logic [CW-1:0]         cnt_q [NumButtons];
  logic [CW-1:0]         cnt_d [NumButtons];

  // Two-flop synchroniser with no logic between the stages.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= btn_i;
      sync2_q <= sync1_q;
    end
  end

  // Debounce: count consecutive cycles where the synchronised input
  // differs from the accepted level. The level toggles when the count completes.
  always_comb begin
    level_d   = level_q;
    press_d   = '0;
    release_d = '0;
    for (int i = 0; i < NumButtons; i++) begin
      cnt_d[i] = cnt_q[i];
      if (sync2_q[i] == level_q[i]) begin
        cnt_d[i] = '0;
      end else if (cnt_q[i] == CntLast) begin
        level_d[i]   = ~level_q[i];
        cnt_d[i]     = '0;
        press_d[i]   = ~level_q[i];
        release_d[i] = level_q[i];
      end else begin
        cnt_d[i] = cnt_q[i] + 1'b1;
      end
    end
  end

`ifdef BUTTON_AUTOREPEAT_EN
  localparam int            RptMax     = (RepeatDelay > RepeatPeriod) ? RepeatDelay : RepeatPeriod;
  localparam int            RW         = $clog2(RptMax + 1);
  localparam logic [RW-1:0] DelayLast  = RW'(RepeatDelay - 1);
  localparam logic [RW-1:0] PeriodLast = RW'(RepeatPeriod - 1);

  logic [RW-1:0]         rpt_cnt_q [NumButtons];
  logic [RW-1:0]         rpt_cnt_d [NumButtons];
  logic [NumButtons-1:0] rpt_first_q, rpt_first_d, rpt_pulse;

  // Repeat timer: restarts on the accepted press and runs while the level stays high.
  // It is cleared in the release cycle, so no repeat pulse can coincide with a release.
  always_comb begin
    rpt_first_d = rpt_first_q;
    rpt_pulse   = '0;
    for (int i = 0; i < NumButtons; i++) begin
      rpt_cnt_d[i] = rpt_cnt_q[i];
      if (press_d[i]) begin
        rpt_cnt_d[i]   = '0;
        rpt_first_d[i] = 1'b1;
      end else if (level_q[i] && !release_d[i]) begin
        if (rpt_cnt_q[i] == (rpt_first_q[i] ? DelayLast : PeriodLast)) begin
          rpt_pulse[i]   = 1'b1;
          rpt_cnt_d[i]   = '0;
          rpt_first_d[i] = 1'b0;
        end else begin
          rpt_cnt_d[i] = rpt_cnt_q[i] + 1'b1;
        end
      end else begin
        rpt_cnt_d[i]   = '0;
        rpt_first_d[i] = 1'b0;
      end
    end
    press_out_d = press_d | rpt_pulse;
  end

  // Repeat timer state.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      rpt_first_q <= '0;
      for (int i = 0; i < NumButtons; i++) rpt_cnt_q[i] <= '0;
    end else begin
      rpt_first_q <= rpt_first_d;
      for (int i = 0; i < NumButtons; i++) rpt_cnt_q[i] <= rpt_cnt_d[i];
    end
  end
`else
  // Without auto-repeat, only accepted presses produce a press pulse.
  always_comb begin
    press_out_d = press_d;
  end
`endif

  // Debounce state and registered outputs.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      level_q   <= '0;
      press_q   <= '0;
      release_q <= '0;
      for (int i = 0; i < NumButtons; i++) cnt_q[i] <= '0;
    end else begin
      level_q   <= level_d;
      press_q   <= press_out_d;
      release_q <= release_d;
      for (int i = 0; i < NumButtons; i++) cnt_q[i] <= cnt_d[i];
    end
  end

  assign btn_level_o   = level_q;
  assign btn_press_o   = press_q;
  assign btn_release_o = release_q;

endmodule

// File: doc/ulx3s_button_receiver.md
Name: ulx3s_button_receiver

Overview:
- Board-side receiver for the ULX3S push-buttons that the simulation runner drives on btn[3:1].
- Synchronizes each asynchronous button input to the fabric clock and debounces it with a per-button counter.
- Produces a clean level plus single-cycle press and release pulses for the sorter control logic.
- Instantiated inside the ulx3s top and clocked from the PLL output clock (20 ns period).

Parameters:
- NumButtons, 3, number of independent button channels.
- DebounceCycles, 50000, consecutive stable cycles required to accept a new level; must be >= 1 (1 ms at 50 MHz).
- RepeatDelay, 25000000, cycles from a press pulse to the first auto-repeat pulse; used only with the optional feature.
- RepeatPeriod, 5000000, cycles between subsequent auto-repeat pulses; used only with the optional feature.

Ports:
- clk_i  input  1  fabric clock (PLL CLKOP).
- reset_i  input  1  synchronous, active-high reset.
- btn_i  input  NumButtons  raw asynchronous button levels, 1 = pressed.
- btn_level_o  output  NumButtons  debounced level.
- btn_press_o  output  NumButtons  one-cycle pulse on each accepted 0->1 transition, and on auto-repeat.
- btn_release_o  output  NumButtons  one-cycle pulse on each accepted 1->0 transition.

Behaviour:
- One clock, clk_i. Reset is synchronous and active-high, on reset_i.
- Reset: synchronizer flops, btn_level_o, btn_press_o, btn_release_o, and all counters are 0. A button held through reset is reported as a press after the normal latency once reset deasserts.
- Synchronizer: two flops per bit (sync1, sync2). No logic between the two flops.
- Debounce, per channel, counter width $clog2(DebounceCycles+1):
  - sync2 == level: counter cleared to 0.
  - sync2 != level and counter < DebounceCycles-1: counter increments.
  - sync2 != level and counter == DebounceCycles-1: level toggles, counter clears, and the matching pulse (press or release) asserts for exactly that cycle.
- Latency: an input change that is stable before edge k appears on btn_level_o and the pulse outputs after edge k+1+DebounceCycles. That is 2+DebounceCycles edges; 3 when DebounceCycles=1.
- Glitch rejection: any reversion of sync2 to the current level before the count completes clears the counter. No output change and no pulse result.
- Pulse and level relationship: a press pulse asserts in the same cycle btn_level_o rises. A release pulse asserts in the same cycle it falls. A channel never asserts press and release in the same cycle.
- Channel independence: channels are fully independent. Simultaneous transitions on several channels produce simultaneous pulses.
- Reset mid-count: reset_i asserted mid-count discards the count and returns the channel to level 0 on the next edge.
- Outputs are registered. No combinational path from btn_i to any output.

Optional Feature:
- Macro: BUTTON_AUTOREPEAT_EN.
- Defined:
  - Each channel has a repeat counter that starts at the press pulse.
  - While btn_level_o stays 1, btn_press_o pulses again RepeatDelay cycles after the press pulse, then every RepeatPeriod cycles.
  - A release or reset clears the repeat counter immediately. No repeat pulse is emitted in or after the release cycle.
  - btn_release_o is unaffected.
- Undefined: no repeat counters exist. btn_press_o pulses exactly once per accepted press.

Test Plan:
- Clean press: DebounceCycles=4, reset, then btn_i[0] 0->1 held -> btn_level_o[0] rises and btn_press_o[0] pulses for 1 cycle exactly 6 edges after the change. Other bits stay 0.
- Bounce rejection: DebounceCycles=4, btn_i[1] toggles high for 3 cycles, low for 1, high for 2, then low -> no pulse and btn_level_o[1] stays 0 throughout.
- Release: DebounceCycles=4, btn_i[2] held high until the level is 1, then dropped -> btn_release_o[2] pulses once 6 edges later and level returns to 0. btn_press_o[2] stays 0 in that window.
- Simultaneous and reset: btn_i=3'b111 with the same timing -> all three press pulses in the same cycle. Asserting reset_i mid-count at cycle 3 -> all outputs stay 0; after release of reset with the buttons held, presses arrive 6 edges later.
- Auto-repeat (BUTTON_AUTOREPEAT_EN, DebounceCycles=2, RepeatDelay=10, RepeatPeriod=4): hold btn_i[0] for 30 cycles -> press pulses at accept, +10, +14, +18, ... Release -> no further pulses.
